// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: addresses, op encodings,
// write masks, status/pending bit positions and reset values.
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_NONE  = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIP_MSIP_BIT     = 3;
  localparam int MIP_MTIP_BIT     = 7;
  localparam int MIP_MEIP_BIT     = 11;

  // MPP is hardwired to machine mode, so these bits always read as set.
  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

  typedef struct packed {
    logic        impl;
    logic        ro;
    logic [31:0] val;
  } csr_rd_t;

  function automatic logic [31:0] csr_rmw(input logic [1:0] op,
                                          input logic [31:0] old,
                                          input logic [31:0] data);
    case (csr_op_e'(op))
      OP_SET:   return old | data;
      OP_CLEAR: return old & ~data;
      default:  return data;
    endcase
  endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access port between the EX/MEM stage and csr_unit.
// A write happens on the clock edge where we_i=1 and op_i!=11; there is no
// backpressure. data_o/illegal_o are combinational on the same cycle.
interface csr_if;
  logic        we_i;
  logic [1:0]  op_i;
  logic [11:0] waddr_i;
  logic [11:0] raddr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        illegal_o;

  modport master (
    output we_i, op_i, waddr_i, raddr_i, data_i,
    input  data_o, illegal_o
  );

  modport slave (
    input  we_i, op_i, waddr_i, raddr_i, data_i,
    output data_o, illegal_o
  );
endinterface

// File: rtl/csr_counter.sv
// Free-running W-bit counter with independently writable low/high 32-bit
// halves; a write to either half suppresses that cycle's increment.
module csr_counter #(
  parameter int W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [31:0] lo,
  output logic [31:0] hi
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (wr_lo) begin
      cnt[31:0] <= wdata;
    end else if (wr_hi) begin
      cnt[W-1:32] <= wdata[W-33:0];
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign lo = cnt[31:0];
  assign hi = 32'(cnt[W-1:32]);
endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: RMW access, masked registers, trap/MRET updates and
// interrupt-pending generation. Counters are built only with CSR_COUNTERS_EN.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int          CNT_WIDTH   = 64
) (
  input  logic        clk,
  input  logic        rst,
  csr_if.slave        bus,
  input  logic        instret_i,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_val_i,
  input  logic        mret_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending_o
);
  logic        st_mie, st_mpie, msip, irq_pending;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [31:0] mstatus_val, mip_val;
  logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
  csr_rd_t     rd_info, wr_info;
  logic        sw_we;
  logic [31:0] wval;

  function automatic csr_rd_t lookup(input logic [11:0] addr);
    csr_rd_t r;
    r.impl = 1'b1;
    r.ro   = 1'b0;
    r.val  = '0;
    case (addr)
      ADDR_MSTATUS:   r.val = mstatus_val;
      ADDR_MISA:      begin r.val = MISA_VALUE; r.ro = 1'b1; end
      ADDR_MIE:       r.val = mie_q;
      ADDR_MTVEC:     r.val = mtvec_q;
      ADDR_MSCRATCH:  r.val = mscratch_q;
      ADDR_MEPC:      r.val = mepc_q;
      ADDR_MCAUSE:    r.val = mcause_q;
      ADDR_MTVAL:     r.val = mtval_q;
      ADDR_MIP:       r.val = mip_val;
      ADDR_MCYCLE:    r.val = mcycle_lo;
      ADDR_MCYCLEH:   r.val = mcycle_hi;
      ADDR_MINSTRET:  r.val = minstret_lo;
      ADDR_MINSTRETH: r.val = minstret_hi;
      ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: r.ro = 1'b1;
      ADDR_MHARTID:   begin r.val = HART_ID; r.ro = 1'b1; end
      default:        begin r.impl = 1'b0; r.ro = 1'b1; end
    endcase
    return r;
  endfunction

  function automatic logic wsel(input logic [11:0] addr);
    return sw_we && (bus.waddr_i == addr);
  endfunction

  always_comb begin
    mstatus_val                   = MSTATUS_RESET;
    mstatus_val[MSTATUS_MIE_BIT]  = st_mie;
    mstatus_val[MSTATUS_MPIE_BIT] = st_mpie;
    mip_val                       = '0;
    mip_val[MIP_MSIP_BIT]         = msip;
    mip_val[MIP_MTIP_BIT]         = irq_timer_i;
    mip_val[MIP_MEIP_BIT]         = irq_ext_i;
  end

  always_comb begin
    rd_info       = lookup(bus.raddr_i);
    wr_info       = lookup(bus.waddr_i);
    sw_we         = bus.we_i && (bus.op_i != OP_NONE) && !wr_info.ro;
    wval          = csr_rmw(bus.op_i, wr_info.val, bus.data_i);
    bus.data_o    = rd_info.val;
    bus.illegal_o = !rd_info.impl ||
                    (bus.we_i && (bus.op_i != OP_NONE) && wr_info.ro);
  end

  // Trap beats MRET beats software on the registers they touch; software
  // writes to any other register still land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_mie      <= 1'b0;
      st_mpie     <= 1'b0;
      msip        <= 1'b0;
      mie_q       <= '0;
      mtvec_q     <= MTVEC_RESET & ALIGN4_MASK;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      irq_pending <= 1'b0;
    end else begin
      if (trap_i) begin
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret_i) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wsel(ADDR_MSTATUS)) begin
        st_mie  <= wval[MSTATUS_MIE_BIT];
        st_mpie <= wval[MSTATUS_MPIE_BIT];
      end

      if (trap_i) begin
        mepc_q   <= trap_pc_i & ALIGN4_MASK;
        mcause_q <= trap_cause_i;
        mtval_q  <= trap_val_i;
      end else begin
        if (wsel(ADDR_MEPC))   mepc_q   <= wval & ALIGN4_MASK;
        if (wsel(ADDR_MCAUSE)) mcause_q <= wval;
        if (wsel(ADDR_MTVAL))  mtval_q  <= wval;
      end

      if (wsel(ADDR_MIE))      mie_q      <= wval & MIE_WMASK;
      if (wsel(ADDR_MTVEC))    mtvec_q    <= wval & ALIGN4_MASK;
      if (wsel(ADDR_MSCRATCH)) mscratch_q <= wval;
      if (wsel(ADDR_MIP))      msip       <= wval[MIP_MSIP_BIT];

      irq_pending <= st_mie && |(mip_val & mie_q);
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter #(.W(CNT_WIDTH)) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wsel(ADDR_MCYCLE)),
    .wr_hi (wsel(ADDR_MCYCLEH)),
    .wdata (wval),
    .lo    (mcycle_lo),
    .hi    (mcycle_hi)
  );

  csr_counter #(.W(CNT_WIDTH)) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_i),
    .wr_lo (wsel(ADDR_MINSTRET)),
    .wr_hi (wsel(ADDR_MINSTRETH)),
    .wdata (wval),
    .lo    (minstret_lo),
    .hi    (minstret_hi)
  );
`else
  assign mcycle_lo   = '0;
  assign mcycle_hi   = '0;
  assign minstret_lo = '0;
  assign minstret_hi = '0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, instret_i, rd_info.ro, wr_info.impl, (CNT_WIDTH > 32)};

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign irq_pending_o = irq_pending;
endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit; counter tests follow CSR_COUNTERS_EN.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instret_i, trap_i, mret_i, irq_timer_i, irq_ext_i;
  logic [31:0] trap_cause_i, trap_pc_i, trap_val_i;
  logic [31:0] mtvec_o, mepc_o;
  logic        irq_pending_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] d;
  logic        ill;

  csr_if bus();

  csr_unit #(
    .HART_ID     (32'h0000_0005),
    .MISA_VALUE  (32'h4000_0100),
    .MTVEC_RESET (32'h0000_2003),
    .CNT_WIDTH   (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .instret_i     (instret_i),
    .trap_i        (trap_i),
    .trap_cause_i  (trap_cause_i),
    .trap_pc_i     (trap_pc_i),
    .trap_val_i    (trap_val_i),
    .mret_i        (mret_i),
    .irq_timer_i   (irq_timer_i),
    .irq_ext_i     (irq_ext_i),
    .mtvec_o       (mtvec_o),
    .mepc_o        (mepc_o),
    .irq_pending_o (irq_pending_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // driver tasks
  task automatic idle();
    bus.we_i     = 1'b0;
    bus.op_i     = OP_NONE;
    bus.waddr_i  = '0;
    bus.raddr_i  = '0;
    bus.data_i   = '0;
    instret_i    = 1'b0;
    trap_i       = 1'b0;
    mret_i       = 1'b0;
    irq_timer_i  = 1'b0;
    irq_ext_i    = 1'b0;
    trap_cause_i = '0;
    trap_pc_i    = '0;
    trap_val_i   = '0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v, output logic i);
    bus.raddr_i = a;
    #1;
    v = bus.data_o;
    i = bus.illegal_o;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] v);
    bus.we_i    = 1'b1;
    bus.waddr_i = a;
    bus.op_i    = op;
    bus.data_i  = v;
    @(negedge clk);
    bus.we_i    = 1'b0;
    bus.op_i    = OP_NONE;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rd(ADDR_MSTATUS, d, ill); checks++;
    if (d !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus: got %h want %h", d, 32'h0000_1800); end
    rd(ADDR_MTVEC, d, ill); checks++;
    if (d !== 32'h0000_2000) begin errors++; $display("FAIL reset_mtvec: got %h want %h", d, 32'h0000_2000); end
    checks++;
    if (mtvec_o !== 32'h0000_2000) begin errors++; $display("FAIL reset_mtvec_o: got %h want %h", mtvec_o, 32'h0000_2000); end
    rd(ADDR_MHARTID, d, ill); checks++;
    if (d !== 32'h5 || ill !== 1'b0) begin errors++; $display("FAIL reset_mhartid: got %h/%b want 5/0", d, ill); end
    rd(ADDR_MISA, d, ill); checks++;
    if (d !== 32'h4000_0100) begin errors++; $display("FAIL reset_misa: got %h want %h", d, 32'h4000_0100); end
    rd(ADDR_MSCRATCH, d, ill); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mscratch: got %h want 0", d); end
    checks++;
    if (mepc_o !== 32'h0 || irq_pending_o !== 1'b0) begin errors++; $display("FAIL reset_mepc_irq: got %h/%b want 0/0", mepc_o, irq_pending_o); end
    rd(12'h7C0, d, ill); checks++;
    if (d !== 32'h0 || ill !== 1'b1) begin errors++; $display("FAIL unimpl_read: got %h/%b want 0/1", d, ill); end
    rst = 1'b1;
`ifdef CSR_COUNTERS_EN
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      rd(ADDR_MCYCLE, d, ill); checks++;
      if (d !== 32'(i)) begin errors++; $display("FAIL mcycle_count: got %0d want %0d", d, i); end
    end
`else
    @(negedge clk);
    rd(ADDR_MCYCLE, d, ill); checks++;
    if (d !== 32'h0 || ill !== 1'b0) begin errors++; $display("FAIL mcycle_absent: got %h/%b want 0/0", d, ill); end
`endif
  endtask

  task automatic test_rmw();
    wr(ADDR_MSCRATCH, OP_WRITE, 32'hF0F0_F0F0);
    rd(ADDR_MSCRATCH, d, ill); checks++;
    if (d !== 32'hF0F0_F0F0) begin errors++; $display("FAIL rmw_write: got %h want %h", d, 32'hF0F0_F0F0); end
    bus.we_i = 1'b1; bus.waddr_i = ADDR_MSCRATCH; bus.op_i = OP_SET; bus.data_i = 32'h0000_000F;
    rd(ADDR_MSCRATCH, d, ill); checks++;
    if (d !== 32'hF0F0_F0F0) begin errors++; $display("FAIL rmw_no_bypass: got %h want %h", d, 32'hF0F0_F0F0); end
    @(negedge clk);
    bus.we_i = 1'b0; bus.op_i = OP_NONE;
    rd(ADDR_MSCRATCH, d, ill); checks++;
    if (d !== 32'hF0F0_F0FF) begin errors++; $display("FAIL rmw_set: got %h want %h", d, 32'hF0F0_F0FF); end
    wr(ADDR_MSCRATCH, OP_CLEAR, 32'hF000_0000);
    rd(ADDR_MSCRATCH, d, ill); checks++;
    if (d !== 32'h00F0_F0FF) begin errors++; $display("FAIL rmw_clear: got %h want %h", d, 32'h00F0_F0FF); end
  endtask

  task automatic test_masks();
    wr(ADDR_MSTATUS, OP_WRITE, 32'hFFFF_FFFF);
    rd(ADDR_MSTATUS, d, ill); checks++;
    if (d !== 32'h0000_1888) begin errors++; $display("FAIL mask_mstatus: got %h want %h", d, 32'h0000_1888); end
    wr(ADDR_MTVEC, OP_WRITE, 32'hFFFF_FFFF);
    rd(ADDR_MTVEC, d, ill); checks++;
    if (d !== 32'hFFFF_FFFC || mtvec_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL mask_mtvec: got %h/%h want %h", d, mtvec_o, 32'hFFFF_FFFC); end
    wr(ADDR_MIE, OP_WRITE, 32'hFFFF_FFFF);
    rd(ADDR_MIE, d, ill); checks++;
    if (d !== 32'h0000_0888) begin errors++; $display("FAIL mask_mie: got %h want %h", d, 32'h0000_0888); end
    wr(ADDR_MEPC, OP_WRITE, 32'h0000_1237);
    rd(ADDR_MEPC, d, ill); checks++;
    if (d !== 32'h0000_1234 || mepc_o !== 32'h0000_1234) begin errors++; $display("FAIL mask_mepc: got %h/%h want %h", d, mepc_o, 32'h0000_1234); end
    wr(ADDR_MIP, OP_WRITE, 32'hFFFF_FFFF);
    rd(ADDR_MIP, d, ill); checks++;
    if (d !== 32'h0000_0008) begin errors++; $display("FAIL mask_mip: got %h want %h", d, 32'h0000_0008); end
    wr(ADDR_MIP, OP_CLEAR, 32'h0000_0008);
    rd(ADDR_MIP, d, ill); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mip_clear: got %h want 0", d); end
    bus.we_i = 1'b1; bus.waddr_i = ADDR_MHARTID; bus.op_i = OP_WRITE; bus.data_i = 32'hFF;
    rd(ADDR_MSTATUS, d, ill); checks++;
    if (ill !== 1'b1) begin errors++; $display("FAIL ro_write_illegal: got %b want 1", ill); end
    @(negedge clk);
    bus.op_i = OP_NONE;
    rd(ADDR_MSTATUS, d, ill); checks++;
    if (ill !== 1'b0) begin errors++; $display("FAIL ro_nop_legal: got %b want 0", ill); end
    bus.waddr_i = 12'h7C0; bus.op_i = OP_SET;
    rd(ADDR_MSTATUS, d, ill); checks++;
    if (ill !== 1'b1) begin errors++; $display("FAIL unimpl_write_illegal: got %b want 1", ill); end
    @(negedge clk);
    bus.we_i = 1'b0; bus.op_i = OP_NONE;
    rd(ADDR_MHARTID, d, ill); checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL mhartid_kept: got %h want 5", d); end
    wr(ADDR_MIE, OP_WRITE, 32'h0);
    wr(ADDR_MSTATUS, OP_WRITE, 32'h0000_0008);
  endtask

  task automatic test_trap();
    rd(ADDR_MSTATUS, d, ill); checks++;
    if (d !== 32'h0000_1808) begin errors++; $display("FAIL pre_trap_mstatus: got %h want %h", d, 32'h0000_1808); end
    trap_i = 1'b1; trap_pc_i = 32'h8000_0102; trap_cause_i = 32'h8000_0007; trap_val_i = 32'hDEAD_BEEF;
    bus.we_i = 1'b1; bus.waddr_i = ADDR_MEPC; bus.op_i = OP_WRITE; bus.data_i = 32'h1111_1110;
    @(negedge clk);
    trap_i = 1'b0; bus.we_i = 1'b0; bus.op_i = OP_NONE;
    rd(ADDR_MEPC, d, ill); checks++;
    if (d !== 32'h8000_0100 || mepc_o !== 32'h8000_0100) begin errors++; $display("FAIL trap_mepc: got %h/%h want %h", d, mepc_o, 32'h8000_0100); end
    rd(ADDR_MCAUSE, d, ill); checks++;
    if (d !== 32'h8000_0007) begin errors++; $display("FAIL trap_mcause: got %h want %h", d, 32'h8000_0007); end
    rd(ADDR_MTVAL, d, ill); checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL trap_mtval: got %h want %h", d, 32'hDEAD_BEEF); end
    rd(ADDR_MSTATUS, d, ill); checks++;
    if (d !== 32'h0000_1880) begin errors++; $display("FAIL trap_mstatus: got %h want %h", d, 32'h0000_1880); end
    mret_i = 1'b1;
    bus.we_i = 1'b1; bus.waddr_i = ADDR_MSTATUS; bus.op_i = OP_WRITE; bus.data_i = 32'h0;
    @(negedge clk);
    mret_i = 1'b0; bus.we_i = 1'b0; bus.op_i = OP_NONE;
    rd(ADDR_MSTATUS, d, ill); checks++;
    if (d !== 32'h0000_1888) begin errors++; $display("FAIL mret_mstatus: got %h want %h", d, 32'h0000_1888); end
    trap_i = 1'b1; mret_i = 1'b1; trap_pc_i = 32'h0000_0200; trap_cause_i = 32'h2; trap_val_i = 32'h0;
    bus.we_i = 1'b1; bus.waddr_i = ADDR_MSCRATCH; bus.op_i = OP_WRITE; bus.data_i = 32'h55;
    @(negedge clk);
    trap_i = 1'b0; mret_i = 1'b0; bus.we_i = 1'b0; bus.op_i = OP_NONE;
    rd(ADDR_MSCRATCH, d, ill); checks++;
    if (d !== 32'h55) begin errors++; $display("FAIL trap_other_write: got %h want 55", d); end
    rd(ADDR_MSTATUS, d, ill); checks++;
    if (d !== 32'h0000_1880) begin errors++; $display("FAIL trap_beats_mret: got %h want %h", d, 32'h0000_1880); end
    rd(ADDR_MEPC, d, ill); checks++;
    if (d !== 32'h0000_0200) begin errors++; $display("FAIL trap2_mepc: got %h want %h", d, 32'h0000_0200); end
    mret_i = 1'b1;
    @(negedge clk);
    mret_i = 1'b0;
  endtask

  task automatic test_irq();
    wr(ADDR_MIE, OP_WRITE, 32'h0000_0080);
    checks++;
    if (irq_pending_o !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq_pending_o); end
    irq_timer_i = 1'b1;
    rd(ADDR_MIP, d, ill); checks++;
    if (d !== 32'h0000_0080 || irq_pending_o !== 1'b0) begin errors++; $display("FAIL irq_live_mip: got %h/%b want 80/0", d, irq_pending_o); end
    @(negedge clk); checks++;
    if (irq_pending_o !== 1'b1) begin errors++; $display("FAIL irq_timer_rise: got %b want 1", irq_pending_o); end
    wr(ADDR_MSTATUS, OP_WRITE, 32'h0);
    checks++;
    if (irq_pending_o !== 1'b1) begin errors++; $display("FAIL irq_mie_lag: got %b want 1", irq_pending_o); end
    @(negedge clk); checks++;
    if (irq_pending_o !== 1'b0) begin errors++; $display("FAIL irq_mie_clear: got %b want 0", irq_pending_o); end
    irq_timer_i = 1'b0;
    wr(ADDR_MIE, OP_WRITE, 32'h0000_0800);
    wr(ADDR_MSTATUS, OP_WRITE, 32'h0000_0008);
    irq_ext_i = 1'b1;
    @(negedge clk); checks++;
    if (irq_pending_o !== 1'b1) begin errors++; $display("FAIL irq_ext_rise: got %b want 1", irq_pending_o); end
    irq_ext_i = 1'b0;
    @(negedge clk); checks++;
    if (irq_pending_o !== 1'b0) begin errors++; $display("FAIL irq_ext_fall: got %b want 0", irq_pending_o); end
  endtask

  task automatic test_counters();
`ifdef CSR_COUNTERS_EN
    wr(ADDR_MCYCLEH, OP_WRITE, 32'h0);
    wr(ADDR_MCYCLE, OP_WRITE, 32'hFFFF_FFFF);
    rd(ADDR_MCYCLE, d, ill); checks++;
    if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_write: got %h want %h", d, 32'hFFFF_FFFF); end
    @(negedge clk);
    rd(ADDR_MCYCLE, d, ill); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mcycle_carry_lo: got %h want 0", d); end
    rd(ADDR_MCYCLEH, d, ill); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL mcycle_carry_hi: got %h want 1", d); end
    wr(ADDR_MCYCLEH, OP_WRITE, 32'h0000_1234);
    rd(ADDR_MCYCLE, d, ill); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mcycleh_write_holds_lo: got %h want 0", d); end
    rd(ADDR_MCYCLEH, d, ill); checks++;
    if (d !== 32'h0000_1234) begin errors++; $display("FAIL mcycleh_write: got %h want %h", d, 32'h0000_1234); end
    @(negedge clk);
    rd(ADDR_MCYCLE, d, ill); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL mcycle_resume: got %h want 1", d); end
    instret_i = 1'b1;
    wr(ADDR_MINSTRET, OP_WRITE, 32'h5);
    rd(ADDR_MINSTRET, d, ill); checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL minstret_write_suppress: got %h want 5", d); end
    @(negedge clk);
    instret_i = 1'b0;
    rd(ADDR_MINSTRET, d, ill); checks++;
    if (d !== 32'h6) begin errors++; $display("FAIL minstret_inc: got %h want 6", d); end
    @(negedge clk);
    rd(ADDR_MINSTRET, d, ill); checks++;
    if (d !== 32'h6) begin errors++; $display("FAIL minstret_hold: got %h want 6", d); end
    wr(ADDR_MINSTRETH, OP_WRITE, 32'hFFFF_FFFF);
    wr(ADDR_MINSTRET, OP_WRITE, 32'hFFFF_FFFF);
    instret_i = 1'b1;
    @(negedge clk);
    instret_i = 1'b0;
    rd(ADDR_MINSTRET, d, ill); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL minstret_wrap_lo: got %h want 0", d); end
    rd(ADDR_MINSTRETH, d, ill); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL minstret_wrap_hi: got %h want 0", d); end
    wr(ADDR_MINSTRET, OP_SET, 32'h0000_00F0);
    rd(ADDR_MINSTRET, d, ill); checks++;
    if (d !== 32'h0000_00F0) begin errors++; $display("FAIL minstret_set: got %h want %h", d, 32'h0000_00F0); end
`else
    bus.we_i = 1'b1; bus.waddr_i = ADDR_MCYCLE; bus.op_i = OP_WRITE; bus.data_i = 32'h1234;
    rd(ADDR_MSTATUS, d, ill); checks++;
    if (ill !== 1'b0) begin errors++; $display("FAIL counter_write_legal: got %b want 0", ill); end
    @(negedge clk);
    bus.we_i = 1'b0; bus.op_i = OP_NONE;
    rd(ADDR_MCYCLE, d, ill); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL counter_write_ignored: got %h want 0", d); end
    rd(ADDR_MINSTRETH, d, ill); checks++;
    if (d !== 32'h0 || ill !== 1'b0) begin errors++; $display("FAIL minstreth_absent: got %h/%b want 0/0", d, ill); end
`endif
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    trap_i = 1'b1; trap_pc_i = 32'h0000_0400; trap_cause_i = 32'h3;
    bus.we_i = 1'b1; bus.waddr_i = ADDR_MSCRATCH; bus.op_i = OP_WRITE; bus.data_i = 32'hAA;
    @(negedge clk);
    idle();
    rd(ADDR_MSCRATCH, d, ill); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midreset_mscratch: got %h want 0", d); end
    rd(ADDR_MSTATUS, d, ill); checks++;
    if (d !== 32'h0000_1800) begin errors++; $display("FAIL midreset_mstatus: got %h want %h", d, 32'h0000_1800); end
    checks++;
    if (mepc_o !== 32'h0 || mtvec_o !== 32'h0000_2000 || irq_pending_o !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got %h/%h/%b want 0/2000/0", mepc_o, mtvec_o, irq_pending_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    idle();
    test_reset();
    test_rmw();
    test_masks();
    test_trap();
    test_irq();
    test_counters();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode control/status register unit for the RISC-V core, successor to the flat CSR array. Adds atomic read-modify-write operations, per-register write masks, hardwired read-only IDs, 64-bit free-running cycle/instret counters, trap-entry and MRET state updates, and interrupt-pending generation. Sits beside the register file. EX/MEM issues CSR accesses; the trap controller drives trap/MRET events and consumes mtvec/mepc/irq_pending.

## Interface
- HART_ID, 0: value returned by mhartid (0xF14)
- MISA_VALUE, 32'h4000_0100: value returned by misa (0x301), RV32I
- MTVEC_RESET, 32'h0000_0000: mtvec reset value, bits [1:0] forced 0
- CNT_WIDTH, 64: mcycle/minstret width, legal 33..64; high CSR returns bits [CNT_WIDTH-1:32], zero-extended
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low
- we_i  in  1  CSR write enable
- op_i  in  2  00 write, 01 set (old|data), 10 clear (old&~data), 11 no write
- waddr_i  in  12  write address
- raddr_i  in  12  read address
- data_i  in  32  write operand
- data_o  out  32  read data, combinational
- illegal_o  out  1  raddr_i unimplemented, or we_i to a read-only/unimplemented address (op_i≠11), combinational
- instret_i  in  1  one instruction retired this cycle
- trap_i  in  1  take trap this cycle
- trap_cause_i / trap_pc_i / trap_val_i  in  32 each  mcause / mepc / mtval values
- mret_i  in  1  execute MRET this cycle
- irq_timer_i, irq_ext_i  in  1 each  level interrupt sources
- mtvec_o, mepc_o  out  32  current register values
- irq_pending_o  out  1  registered interrupt request

## Operation
- Implemented: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, mvendorid/marchid/mimpid 0xF11-0xF13 (read 0), mhartid 0xF14.
- RMW old value is the register addressed by waddr_i; result passes through that register's write mask.
- Masks: mstatus MIE[3], MPIE[7] writable, MPP[12:11] reads 2'b11; mie bits 3/7/11 only; mip MSIP[3] writable, MTIP[7] = irq_timer_i, MEIP[11] = irq_ext_i (read live); mtvec, mepc bits [1:0] read 0; other RW regs full 32 bits.
- Read-only or unimplemented write: no state change, illegal_o=1.
- Unimplemented read: data_o=0, illegal_o=1.
- Trap: mepc←trap_pc_i&~3, mcause←trap_cause_i, mtval←trap_val_i, MPIE←MIE, MIE←0.
- MRET: MIE←MPIE, MPIE←1.
- Same-cycle priority: rst > trap_i > mret_i > software write; a write losing on the same register is dropped, writes to unaffected registers proceed.
- Counters: mcycle +1 every cycle, minstret +1 when instret_i; wrap all-ones→0. Software write to a half replaces that half, other half holds, and suppresses the increment that cycle.
- irq_pending_o ← MIE & |(mip & mie), registered.

## Timing
- Reset (rst=0 at clk edge): mstatus=0x1800, mtvec=MTVEC_RESET, all other RW regs and counters 0, irq_pending_o=0. data_o/illegal_o follow raddr_i.
- Read latency 0, combinational; write/trap/MRET visible next cycle. No read-during-write bypass; same-cycle read returns the old value.
- irq_pending_o lags irq inputs/mie/MIE by one cycle.
- Reset mid-operation discards any concurrent write, trap or MRET.

## Configuration
- CSR_COUNTERS_EN defined: mcycle/minstret counters built as above.
- Undefined: counter addresses read 0, illegal_o=0, writes ignored; no counter flops.

## Structure
- csr_pkg: CSR address constants, op_i encodings, write masks, mstatus/mip bit positions, reset constants.
- Sub-module csr_counter (CNT_WIDTH, increment enable, low/high write ports), instantiated for mcycle and minstret.

## Test plan
- Reset, then read mstatus/mtvec/mhartid -> 0x1800 / MTVEC_RESET / HART_ID; mcycle counts 1,2,3... from reset release.
- mscratch write 0xF0F0_F0F0, set 0x0000_000F, clear 0xF000_0000 -> reads 0xF0F0_F0F0, 0xF0F0_F0FF, 0x00F0_F0FF on successive cycles.
- Write 0xFFFF_FFFF to mstatus and mtvec -> 0x1888 and 0xFFFF_FFFC; write to mhartid -> illegal_o=1, value unchanged.
- MIE=1, trap_i with pc 0x8000_0102, cause 0x8000_0007 -> mepc 0x8000_0100, mstatus 0x1880; then mret_i -> mstatus 0x1888.
- Trap and software mepc write same cycle -> mepc = trap value; mcycle=0xFFFF_FFFF then one cycle -> mcycle 0, mcycleh +1.
- mie=0x80, MIE=1, irq_timer_i rises -> irq_pending_o=1 one cycle later; MIE cleared -> 0 one cycle after.
